// File: rtl/axil_pkg.sv
// Shared constants and helpers for the AXI4-Lite slave memory.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Ceiling log2, usable in localparam expressions (clog2(1) = 0).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/axil_mem_bank.sv
// DEPTH x DATA_WIDTH RAM: one byte-enabled write port, one registered read
// port. A read and a write to the same word in one cycle return the old word.
module axil_mem_bank
    import axil_pkg::*;
#(
    parameter int DEPTH      = 256,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = clog2(DEPTH)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    wr_en_i,
    input  logic [IDX_W-1:0]        wr_idx_i,
    input  logic [DATA_WIDTH-1:0]   wr_data_i,
    input  logic [DATA_WIDTH/8-1:0] wr_strb_i,
    input  logic                    rd_en_i,
    input  logic [IDX_W-1:0]        rd_idx_i,
    output logic [DATA_WIDTH-1:0]   rd_data_o
);

    localparam int STRB_W = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Byte-lane writes; storage is deliberately not reset.
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_strb_i[b]) begin
                    mem_q[wr_idx_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
                end
            end
        end
    end

    // Registered read; samples the array before any same-edge write lands.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_idx_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axil_slave_mem.sv
// AXI4-Lite slave in front of a byte-writable on-chip memory.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. A source holds valid and its payload stable until that edge.
// awready/wready/arready never look at their own valid input; arready looks
// only at rready and internal state.
//
// Write path: AW and W each land in a one-entry holding register, in any
// order. Once both are full and the B slot is free (or being emptied this
// cycle) the write commits: in-range words take the strobed bytes with OKAY,
// out-of-range addresses leave memory alone and answer SLVERR.
// Read path: the AR handshake launches the RAM read; the next cycle presents
// rvalid with the data (or zero plus SLVERR when out of range).
module axil_slave_mem
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 256
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int ALIGN  = clog2(STRB_W);
    localparam int IDX_W  = clog2(DEPTH);
    localparam int HI     = ALIGN + IDX_W;

    // An address is in range when every bit above the word index is zero.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        return (addr >> HI) == '0;
    endfunction

    logic                    ready_en_q, ready_en_d;
    logic                    aw_full_q,  aw_full_d;
    logic [ADDR_WIDTH-1:0]   aw_addr_q,  aw_addr_d;
    logic                    w_full_q,   w_full_d;
    logic [DATA_WIDTH-1:0]   w_data_q,   w_data_d;
    logic [STRB_W-1:0]       w_strb_q,   w_strb_d;
    logic                    bvalid_q,   bvalid_d;
    logic [1:0]              bresp_q,    bresp_d;
    logic                    rvalid_q,   rvalid_d;
    logic                    rerr_q,     rerr_d;

    logic                    aw_hs, w_hs, ar_hs, commit;
    logic                    bank_wr_en, bank_rd_en;
    logic [DATA_WIDTH-1:0]   bank_rdata;
    logic                    unused_addr_bits;

    // ready_en_q keeps every ready low until the first edge after reset.
    assign awready = ready_en_q && !aw_full_q;
    assign wready  = ready_en_q && !w_full_q;
    assign arready = ready_en_q && (!rvalid_q || rready);

    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign ar_hs  = arvalid && arready;
    assign commit = aw_full_q && w_full_q && (!bvalid_q || bready);

    assign bank_wr_en = commit && in_range(aw_addr_q);
    assign bank_rd_en = ar_hs && in_range(araddr);

    assign bvalid = bvalid_q;
    assign bresp  = bresp_q;
    assign rvalid = rvalid_q;
    assign rresp  = rerr_q ? RESP_SLVERR : RESP_OKAY;
    assign rdata  = rerr_q ? '0 : bank_rdata;

    // Sub-word address bits select nothing in a full-word access.
    assign unused_addr_bits = ^{aw_addr_q[ALIGN-1:0], araddr[ALIGN-1:0]};

    // Next state for holding registers and both response channels.
    always_comb begin
        ready_en_d = 1'b1;
        aw_full_d  = aw_full_q;
        aw_addr_d  = aw_addr_q;
        w_full_d   = w_full_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        rvalid_d   = rvalid_q;
        rerr_d     = rerr_q;

        // A commit empties both holding slots; a full slot never handshakes,
        // so a commit and a refill of the same slot cannot coincide.
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
        end
        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_addr_d = awaddr;
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = wdata;
            w_strb_d = wstrb;
        end

        if (commit) begin
            bvalid_d = 1'b1;
            bresp_d  = in_range(aw_addr_q) ? RESP_OKAY : RESP_SLVERR;
        end else if (bready) begin
            bvalid_d = 1'b0;
        end

        if (ar_hs) begin
            rvalid_d = 1'b1;
            rerr_d   = !in_range(araddr);
        end else if (rready) begin
            rvalid_d = 1'b0;
        end
    end

    // State registers; reset drops every pending AW/W/B/R item.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ready_en_q <= 1'b0;
            aw_full_q  <= 1'b0;
            aw_addr_q  <= '0;
            w_full_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rvalid_q   <= 1'b0;
            rerr_q     <= 1'b0;
        end else begin
            ready_en_q <= ready_en_d;
            aw_full_q  <= aw_full_d;
            aw_addr_q  <= aw_addr_d;
            w_full_q   <= w_full_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rerr_q     <= rerr_d;
        end
    end

    axil_mem_bank #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_bank (
        .clock     (clock),
        .reset     (reset),
        .wr_en_i   (bank_wr_en),
        .wr_idx_i  (aw_addr_q[ALIGN +: IDX_W]),
        .wr_data_i (w_data_q),
        .wr_strb_i (w_strb_q),
        .rd_en_i   (bank_rd_en),
        .rd_idx_i  (araddr[ALIGN +: IDX_W]),
        .rd_data_o (bank_rdata)
    );

endmodule

// File: tb/tb_axil_slave_mem.sv
// Bench for axil_slave_mem (32-bit data, 256 words): directed scenarios plus
// randomized traffic against a word-array reference model.
`timescale 1ns/1ps
module tb_axil_slave_mem;
    import axil_pkg::*;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 256;

    // ---------------- clock / reset ----------------
    logic          clock = 1'b0;
    logic          reset = 1'b1;
    always #5 clock = ~clock;

    logic [AW-1:0] awaddr  = '0;
    logic          awvalid = 1'b0;
    logic          awready;
    logic [DW-1:0] wdata   = '0;
    logic [3:0]    wstrb   = '0;
    logic          wvalid  = 1'b0;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready  = 1'b0;
    logic [AW-1:0] araddr  = '0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready  = 1'b1;

    axil_slave_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- reference model / scoreboard ----------------
    logic [31:0] model_mem [DEPTH];
    logic [1:0]  b_exp_q[$];
    logic [33:0] r_exp_q[$];   // {rresp, rdata}
    int          r_hs_cyc[$];
    bit          rr_random = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Byte address -> word; anything at or past DEPTH*4 bytes is out of range.
    function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                               input logic [3:0] strb);
        int idx;
        if (addr >= DEPTH * 4) return RESP_SLVERR;
        idx = int'(addr / 4);
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) model_mem[idx][8*b +: 8] = data[8*b +: 8];
        end
        return RESP_OKAY;
    endfunction

    function automatic logic [33:0] model_read(input logic [31:0] addr);
        if (addr >= DEPTH * 4) return {RESP_SLVERR, 32'h0};
        return {RESP_OKAY, model_mem[int'(addr / 4)]};
    endfunction

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0) begin
            if ($urandom_range(0, 1) == 0) return 32'h400 + 32'($urandom_range(0, 1023));
            return 32'h8000_0000 | 32'($urandom_range(0, 127));
        end
        return 32'($urandom_range(0, 127));
    endfunction

    // ---------------- monitors ----------------
    logic [33:0] r_e;
    logic [33:0] r_hold_v;
    bit          r_held = 1'b0;

    initial forever begin
        @(negedge clock);
        rready = rr_random ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Handshake at the coming edge is decided here, mid-low-phase.
    initial forever begin
        @(negedge clock);
        #2;
        if (reset) begin
            r_held = 1'b0;
        end else begin
            if (bvalid && bready) begin
                if (b_exp_q.size() == 0) check_eq("b_unexpected", 1, 0);
                else check_eq("bresp", bresp, b_exp_q.pop_front());
            end
            if (rvalid && rready) begin
                r_hs_cyc.push_back(cyc);
                if (r_exp_q.size() == 0) begin
                    check_eq("r_unexpected", 1, 0);
                end else begin
                    r_e = r_exp_q.pop_front();
                    check_eq("rdata", rdata, r_e[31:0]);
                    check_eq("rresp", rresp, r_e[33:32]);
                end
                r_held = 1'b0;
            end else if (rvalid) begin
                if (r_held) check_eq("r_stable", {rresp, rdata}, r_hold_v);
                r_held   = 1'b1;
                r_hold_v = {rresp, rdata};
            end else begin
                r_held = 1'b0;
            end
        end
    end

    // ---------------- driver tasks (entered at a negedge) ----------------
    task automatic send_aw(input logic [31:0] addr, input int lead);
        repeat (lead) @(negedge clock);
        awaddr  = addr;
        awvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (awready) begin
                @(negedge clock);
                awvalid = 1'b0;
                return;
            end
            @(negedge clock);
        end
        check_eq("aw_timeout", 0, 1);
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input int lead);
        repeat (lead) @(negedge clock);
        wdata  = data;
        wstrb  = strb;
        wvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (wready) begin
                @(negedge clock);
                wvalid = 1'b0;
                return;
            end
            @(negedge clock);
        end
        check_eq("w_timeout", 0, 1);
        wvalid = 1'b0;
    endtask

    // Returns 1 ns after a negedge once bvalid is seen.
    task automatic wait_bvalid(output bit ok);
        int n;
        n = 0;
        #1;
        while (!bvalid && n < 50) begin
            @(negedge clock);
            #1;
            n++;
        end
        ok = bvalid;
        if (!ok) check_eq("b_timeout", 0, 1);
    endtask

    task automatic b_accept(input int delay);
        bit ok;
        wait_bvalid(ok);
        if (!ok) return;
        repeat (delay) begin
            @(negedge clock);
            #1;
            check_eq("b_hold_valid", bvalid, 1);
            if (b_exp_q.size() > 0) check_eq("b_hold_resp", bresp, b_exp_q[0]);
        end
        @(negedge clock);
        bready = 1'b1;
        @(negedge clock);
        bready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_lead, input int w_lead, input int b_delay);
        b_exp_q.push_back(model_write(addr, data, strb));
        fork
            send_aw(addr, aw_lead);
            send_w(data, strb, w_lead);
        join
        b_accept(b_delay);
    endtask

    // Leaves arvalid high on return so consecutive calls issue back to back.
    task automatic read_issue(input logic [31:0] addr, input logic [33:0] exp);
        r_exp_q.push_back(exp);
        araddr  = addr;
        arvalid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (arready) begin
                @(negedge clock);
                return;
            end
            @(negedge clock);
        end
        check_eq("ar_timeout", 0, 1);
    endtask

    task automatic r_drain();
        arvalid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (r_exp_q.size() == 0) begin
                @(negedge clock);
                return;
            end
            @(negedge clock);
        end
        check_eq("r_drain_timeout", r_exp_q.size(), 0);
        r_exp_q.delete();
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [33:0] exp);
        read_issue(addr, exp);
        r_drain();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit ok;

        // 1: outputs during reset, readys one cycle after release
        repeat (3) @(negedge clock);
        check_eq("rst_awready", awready, 0);
        check_eq("rst_wready",  wready,  0);
        check_eq("rst_arready", arready, 0);
        check_eq("rst_bvalid",  bvalid,  0);
        check_eq("rst_bresp",   bresp,   0);
        check_eq("rst_rvalid",  rvalid,  0);
        check_eq("rst_rdata",   rdata,   0);
        check_eq("rst_rresp",   rresp,   0);
        reset = 1'b0;
        @(negedge clock);
        check_eq("rel_awready", awready, 1);
        check_eq("rel_wready",  wready,  1);
        check_eq("rel_arready", arready, 1);
        check_eq("rel_bvalid",  bvalid,  0);
        check_eq("rel_rvalid",  rvalid,  0);

        // Give the words used below known contents.
        for (int i = 0; i < 32; i++) do_write(32'(i * 4), $urandom, 4'hF, 0, 0, 0);

        // 2: full write, then byte-0 write, then read back
        do_write(32'h010, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        do_write(32'h010, 32'h000000AA, 4'h1, 0, 0, 1);
        do_read(32'h010, {RESP_OKAY, 32'hDEADBEAA});

        // 3: W three cycles ahead of AW, bready low five cycles
        b_exp_q.push_back(model_write(32'h044, 32'h12345678, 4'hF));
        send_w(32'h12345678, 4'hF, 0);
        #1;
        check_eq("t3_wready_low", wready, 0);
        @(negedge clock);
        @(negedge clock);
        send_aw(32'h044, 0);
        b_exp_q.push_back(model_write(32'h404, 32'hCAFEF00D, 4'hF));
        fork
            send_aw(32'h404, 0);
            send_w(32'hCAFEF00D, 4'hF, 0);
        join
        #1;
        check_eq("t3_aw_blocked", awready, 0);
        check_eq("t3_w_blocked",  wready,  0);
        check_eq("t3_bvalid",     bvalid,  1);
        check_eq("t3_bresp_first", bresp,  RESP_OKAY);
        @(negedge clock);
        b_accept(5);
        b_accept(0);
        do_read(32'h044, {RESP_OKAY, 32'h12345678});

        // 4: out-of-range write and read; word 0 untouched
        do_write(32'h400, 32'h55AA55AA, 4'hF, 0, 1, 0);
        do_read(32'h400, {RESP_SLVERR, 32'h0});
        do_read(32'h000, model_read(32'h000));

        // 5: back-to-back reads, rready held, then rready toggling
        r_hs_cyc.delete();
        for (int i = 0; i < 4; i++) read_issue(32'(i * 4), model_read(32'(i * 4)));
        r_drain();
        check_eq("b2b_count", r_hs_cyc.size(), 4);
        if (r_hs_cyc.size() == 4) check_eq("b2b_span", r_hs_cyc[3] - r_hs_cyc[0], 3);
        rr_random = 1'b1;
        r_hs_cyc.delete();
        for (int i = 0; i < 4; i++) read_issue(32'(i * 4), model_read(32'(i * 4)));
        r_drain();
        rr_random = 1'b0;
        check_eq("toggle_count", r_hs_cyc.size(), 4);

        // 6a: read of 0x020 on the same edge as a write commit to it
        do_write(32'h020, 32'h11111111, 4'hF, 0, 0, 0);
        @(negedge clock);
        awaddr = 32'h020; wdata = 32'h22222222; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        #1;
        check_eq("t6_aw_w_ready", {awready, wready}, 2'b11);
        @(negedge clock);
        awvalid = 1'b0; wvalid = 1'b0;
        r_exp_q.push_back({RESP_OKAY, 32'h11111111});
        araddr = 32'h020; arvalid = 1'b1;
        #1;
        check_eq("t6_arready", arready, 1);
        @(negedge clock);
        arvalid = 1'b0;
        b_exp_q.push_back(model_write(32'h020, 32'h22222222, 4'hF));
        b_accept(0);
        r_drain();
        do_read(32'h020, {RESP_OKAY, 32'h22222222});

        // 6b: reset while bvalid is up
        b_exp_q.push_back(model_write(32'h024, 32'h0BADCAFE, 4'hF));
        fork
            send_aw(32'h024, 0);
            send_w(32'h0BADCAFE, 4'hF, 0);
        join
        wait_bvalid(ok);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_bvalid",  bvalid,  0);
        check_eq("mid_rst_awready", awready, 0);
        b_exp_q.delete();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_eq("mid_rel_awready", awready, 1);
        check_eq("mid_rel_bvalid",  bvalid,  0);
        do_read(32'h024, {RESP_OKAY, 32'h0BADCAFE});
        do_read(32'h020, {RESP_OKAY, 32'h22222222});

        // Randomized mix of writes and read bursts
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 2) != 0) begin
                do_write(rand_addr(), $urandom, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            end else begin
                int n;
                logic [31:0] a;
                n = $urandom_range(1, 4);
                rr_random = 1'($urandom_range(0, 1));
                for (int k = 0; k < n; k++) begin
                    a = rand_addr();
                    read_issue(a, model_read(a));
                end
                r_drain();
                rr_random = 1'b0;
            end
        end

        repeat (3) @(negedge clock);
        check_eq("b_queue_empty", b_exp_q.size(), 0);
        check_eq("r_queue_empty", r_exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axil_slave_mem.md
# axil_slave_mem

Parametrised AXI4-Lite slave backed by on-chip byte-writable memory. It is the successor to the fixed 32-bit/256-word slave. It adds:
- configurable data width, address width and depth;
- WSTRB byte enables;
- independent AW/W acceptance;
- SLVERR for out-of-range accesses;
- back-to-back reads.

It sits between the RISC-V core or accelerator AXI-Lite master and local data or weight storage.

## Interface
- ADDR_WIDTH, 32, byte-address width
- DATA_WIDTH, 32, data width; 32 or 64
- DEPTH, 256, words; power of two; DEPTH*DATA_WIDTH/8 ≤ 2^ADDR_WIDTH
- clock  in  1  clock
- reset  in  1  asynchronous, active-high
- awaddr  in  ADDR_WIDTH  write byte address
- awvalid / awready  in / out  1  write-address handshake
- wdata  in  DATA_WIDTH  write data
- wstrb  in  DATA_WIDTH/8  byte enables
- wvalid / wready  in / out  1  write-data handshake
- bresp  out  2  write response
- bvalid / bready  out / in  1  write-response handshake
- araddr  in  ADDR_WIDTH  read byte address
- arvalid / arready  in / out  1  read-address handshake
- rdata  out  DATA_WIDTH  read data
- rresp  out  2  read response
- rvalid / rready  out / in  1  read-data handshake

## Operation
**Address decode**
- ALIGN = log2(DATA_WIDTH/8).
- Word index = addr[ALIGN+log2(DEPTH)-1 : ALIGN].
- addr[ALIGN-1:0] is ignored.
- Any nonzero bit above the index is out of range.

**Write path**
- One-entry AW holding register with aw_full flag; one-entry W holding register with w_full flag.
- awready = !aw_full; wready = !w_full.
- AW and W may arrive in either order or in the same cycle.
- Commit condition: aw_full && w_full && (!bvalid || bready).
- On commit:
  - in range: write bytes with wstrb[i]=1, bresp=OKAY (2'b00);
  - out of range: memory untouched, bresp=SLVERR (2'b10);
  - bvalid<=1; aw_full and w_full cleared.
- wstrb=0 in range is a legal no-op with OKAY.
- bvalid/bresp hold until bready.

**Read path**
- arready = !rvalid || rready, giving one read per cycle when rready is held high.
- On AR handshake, the next cycle presents rvalid=1 and:
  - in range: rdata=mem[index], rresp=OKAY;
  - out of range: rdata=0, rresp=SLVERR.
- rdata/rresp are stable while rvalid && !rready.

**Boundary conditions**
- Read and write commit to the same word in the same cycle: read returns the old data.
- Reset asserted mid-transaction: all pending AW/W/B/R state is dropped. Memory contents are not reset.

## Timing
- Reset values: awready=0, wready=0, bvalid=0, bresp=0, arready=0, rvalid=0, rdata=0, rresp=0.
- awready, wready and arready rise in the first cycle after reset deassertion.
- Write latency:
  - AW+W accepted at cycle edge N → commit at edge N+1 → bvalid high during cycle N+1.
  - With bready held high, sustained write throughput is 1 per 2 cycles.
- Read latency: AR accepted at edge N → rvalid high during cycle N (registered output, visible the cycle after handshake); throughput 1 per cycle.
- No combinational path from any valid input to its own ready output. arready depends on rready only.

## Structure
- Package axil_pkg holds:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
  - function clog2 for ALIGN and index width.
- Sub-module axil_mem_bank is a DEPTH x DATA_WIDTH RAM with:
  - one write port with byte enables;
  - one registered read port;
  - read-before-write semantics.
- Top level contains the AW/W holding registers, response registers and decode.

## Test plan
Defaults apply: DATA_WIDTH=32, DEPTH=256.
1. Reset release → all outputs 0 during reset; the cycle after, awready=wready=arready=1; rvalid=bvalid=0.
2. Write 0xDEADBEEF to 0x010 with wstrb=4'hF, then write 0x000000AA with wstrb=4'h1, then read 0x010 → bresp=OKAY twice; rdata=0xDEADBEAA, rresp=OKAY.
3. W presented 3 cycles before AW, with bready held low 5 cycles → wready low after W accepted; single bvalid held stable until bready; no second write accepted meanwhile.
4. Write and read to 0x400 (out of range) → bresp=SLVERR; rdata=0, rresp=SLVERR; word 0x000 unchanged.
5. Four back-to-back reads of 0x000, 0x004, 0x008, 0x00C with rready=1 → four consecutive rvalid cycles with correct data. Repeat with rready toggling → no data lost or duplicated.
6. Simultaneous write commit and read of 0x020 (old 0x11111111, new 0x22222222) → read returns 0x11111111, next read 0x22222222. Reset asserted while bvalid=1 → bvalid=0 immediately.
